// File: rtl/imem_boot_rom.sv
// Loadable boot instruction memory: cleared to NOP after reset, optionally loaded over a word port, then fetched.
// Optional per-word even parity with fault injection is enabled by defining IMEM_PARITY_EN.
module imem_boot_rom #(
    parameter int              DEPTH    = 128,
    parameter int              ADDR_W   = 12,
    parameter int              DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     boot_load,
    input  logic                     load_valid,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [DATA_W-1:0]        load_data,
    input  logic                     load_last,
`ifdef IMEM_PARITY_EN
    input  logic                     load_perr_inj,
`endif
    output logic                     load_ready,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     fetch_ready,
    output logic                     fetch_valid,
    output logic [DATA_W-1:0]        fetch_inst,
    output logic                     fetch_err,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);

`ifdef IMEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int WORD_W = DATA_W + PAR_W;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              fetch_valid_q;
    logic [DATA_W-1:0] fetch_inst_q;
    logic              fetch_err_q;

    logic [WORD_W-1:0] mem_q [DEPTH];

    logic              wr_en;
    logic [AW-1:0]     wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              wr_inj;
    logic [WORD_W-1:0] wr_word;

    logic              fetch_acc;
    logic [AW-1:0]     rd_idx;
    logic [WORD_W-1:0] rd_word;
    logic              rd_misalign;
    logic              rd_range;
    logic              rd_par;
    logic              rd_fault;

    assign load_ready  = (state_q == ST_LOAD);
    assign fetch_ready = (state_q == ST_RUN);
    assign busy        = (state_q != ST_RUN);
    assign fetch_valid = fetch_valid_q;
    assign fetch_inst  = fetch_inst_q;
    assign fetch_err   = fetch_err_q;

    // NOTE: every signal driven here gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = cnt_q;
        wr_data = NOP_WORD;
        wr_inj  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                wr_en = 1'b1;
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = boot_load ? ST_LOAD : ST_RUN;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    wr_en   = 1'b1;
                    wr_idx  = load_addr;
                    wr_data = load_data;
`ifdef IMEM_PARITY_EN
                    wr_inj  = load_perr_inj;
`endif
                    if (load_last) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_CLEAR;
        endcase
    end

`ifdef IMEM_PARITY_EN
    assign wr_word = {(^wr_data) ^ wr_inj, wr_data};
`else
    assign wr_word = wr_data;
`endif

    assign fetch_acc   = fetch_req & fetch_ready;
    assign rd_idx      = fetch_addr[AW+1:2];
    assign rd_word     = mem_q[rd_idx];
    assign rd_misalign = (fetch_addr[1:0] != 2'b00);
    assign rd_range    = (32'(fetch_addr[ADDR_W-1:2]) >= 32'(DEPTH));
`ifdef IMEM_PARITY_EN
    assign rd_par      = ^rd_word;
`else
    assign rd_par      = 1'b0;
`endif
    assign rd_fault    = rd_misalign | rd_range | rd_par;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_CLEAR;
            cnt_q         <= '0;
            fetch_valid_q <= 1'b0;
            fetch_inst_q  <= NOP_WORD;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fetch_valid_q <= fetch_acc;
            if (fetch_acc) begin
                fetch_inst_q <= rd_fault ? NOP_WORD : rd_word[DATA_W-1:0];
                fetch_err_q  <= rd_fault;
            end
        end
    end

    // NOTE: the array has no reset; the CLEAR sweep initialises it so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_word;
        end
    end

    // Tie-off for the unused upper read-word bit when parity is disabled is not needed: widths match.
    logic unused_ok;
    assign unused_ok = wr_inj;

endmodule

// File: tb/tb_imem_boot_rom.sv
// Directed-vector bench for imem_boot_rom at DEPTH = 128; parity cases run when IMEM_PARITY_EN is defined.
module tb_imem_boot_rom;

    localparam int          DEPTH  = 128;
    localparam int          ADDR_W = 12;
    localparam int          DATA_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset;
    logic              boot_load;
    logic              load_valid;
    logic [6:0]        load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_perr_inj;
    logic              load_ready;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_inst;
    logic              fetch_err;
    logic              busy;

    int vectors = 0;
    int errors  = 0;

    imem_boot_rom #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_WORD(NOP)) dut (
        .clk         (clk),
        .reset       (reset),
        .boot_load   (boot_load),
        .load_valid  (load_valid),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_last   (load_last),
`ifdef IMEM_PARITY_EN
        .load_perr_inj(load_perr_inj),
`endif
        .load_ready  (load_ready),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_inst  (fetch_inst),
        .fetch_err   (fetch_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_valid    = 1'b0;
        load_addr     = '0;
        load_data     = '0;
        load_last     = 1'b0;
        load_perr_inj = 1'b0;
        fetch_req     = 1'b0;
        fetch_addr    = '0;
    endtask

    task automatic apply_reset(input logic boot);
        reset     = 1'b1;
        boot_load = boot;
        idle_inputs();
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (busy === 1'b1 && load_ready !== 1'b1 && n < DEPTH + 20) begin
            tick();
            n++;
        end
    endtask

    task automatic load_word(input logic [6:0] idx, input logic [31:0] data, input logic last,
                             input logic inj);
        load_valid    = 1'b1;
        load_addr     = idx;
        load_data     = data;
        load_last     = last;
        load_perr_inj = inj;
        tick();
        idle_inputs();
    endtask

    // Drives one request; returns valid after the accepting edge, the response, and valid one cycle later.
    task automatic do_fetch(input logic [ADDR_W-1:0] addr, output logic v1, output logic [31:0] inst,
                            output logic err, output logic v2);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        tick();
        v1   = fetch_valid;
        inst = fetch_inst;
        err  = fetch_err;
        fetch_req = 1'b0;
        tick();
        v2 = fetch_valid;
    endtask

    task automatic expect_fetch(input string name, input logic [ADDR_W-1:0] addr,
                                input logic [31:0] exp_inst, input logic exp_err);
        logic v1, v2, err;
        logic [31:0] inst;
        do_fetch(addr, v1, inst, err, v2);
        vectors++;
        if (v1 !== 1'b1 || v2 !== 1'b0 || inst !== exp_inst || err !== exp_err) begin
            errors++;
            $display("FAIL %s addr=%h: got valid=%b/%b inst=%h err=%b, want valid=1/0 inst=%h err=%b",
                     name, addr, v1, v2, inst, err, exp_inst, exp_err);
        end
    endtask

    task automatic test_reset();
        int n;
        reset     = 1'b1;
        boot_load = 1'b0;
        idle_inputs();
        repeat (2) tick();
        vectors++;
        if (fetch_valid !== 1'b0 || fetch_inst !== NOP || fetch_err !== 1'b0 ||
            load_ready !== 1'b0 || fetch_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: got v=%b inst=%h err=%b lr=%b fr=%b busy=%b, want 0 %h 0 0 0 1",
                     fetch_valid, fetch_inst, fetch_err, load_ready, fetch_ready, busy, NOP);
        end
        reset = 1'b0;
        wait_clear(n);
        vectors++;
        if (n !== DEPTH) begin
            errors++;
            $display("FAIL clear_length: got %0d busy cycles, want %0d", n, DEPTH);
        end
        vectors++;
        if (fetch_ready !== 1'b1 || load_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL run_entry: got fr=%b lr=%b busy=%b, want 1 0 0", fetch_ready, load_ready, busy);
        end
        expect_fetch("clear_word0", 12'h000, NOP, 1'b0);
        expect_fetch("clear_word127", 12'h1FC, NOP, 1'b0);
    endtask

    task automatic test_load();
        int n;
        apply_reset(1'b1);
        wait_clear(n);
        vectors++;
        if (n !== DEPTH || load_ready !== 1'b1 || busy !== 1'b1 || fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_entry: got n=%0d lr=%b busy=%b fr=%b, want %0d 1 1 0",
                     n, load_ready, busy, fetch_ready, DEPTH);
        end
        fetch_req  = 1'b1;
        fetch_addr = 12'h000;
        tick();
        fetch_req = 1'b0;
        tick();
        vectors++;
        if (fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_in_load_ignored: got valid=%b, want 0", fetch_valid);
        end
        load_word(7'd5, 32'h2000_0537, 1'b0, 1'b0);
        load_word(7'd0, 32'h0010_0093, 1'b0, 1'b0);
        load_word(7'd1, 32'h0020_0113, 1'b0, 1'b0);
        load_word(7'd2, 32'h0030_0193, 1'b0, 1'b0);
        vectors++;
        if (load_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_stays: got lr=%b busy=%b, want 1 1", load_ready, busy);
        end
        load_word(7'd5, 32'h00B5_2023, 1'b1, 1'b0);
        vectors++;
        if (load_ready !== 1'b0 || fetch_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_last_exit: got lr=%b fr=%b busy=%b, want 0 1 0", load_ready, fetch_ready, busy);
        end
        expect_fetch("last_write_wins", 12'h014, 32'h00B5_2023, 1'b0);
    endtask

    task automatic test_faults();
        expect_fetch("misaligned", 12'h016, NOP, 1'b1);
        expect_fetch("out_of_range", 12'h200, NOP, 1'b1);
        expect_fetch("recover", 12'h014, 32'h00B5_2023, 1'b0);
        repeat (2) tick();
        vectors++;
        if (fetch_valid !== 1'b0 || fetch_inst !== 32'h00B5_2023 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL hold: got v=%b inst=%h err=%b, want 0 00b52023 0", fetch_valid, fetch_inst, fetch_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h0010_0093;
        exp_w[1] = 32'h0020_0113;
        exp_w[2] = 32'h0030_0193;
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_addr = ADDR_W'(i * 4);
            tick();
            vectors++;
            if (fetch_valid !== 1'b1 || fetch_inst !== exp_w[i] || fetch_err !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got v=%b inst=%h err=%b, want 1 %h 0",
                         i, fetch_valid, fetch_inst, fetch_err, exp_w[i]);
            end
        end
        fetch_req = 1'b0;
        tick();
        vectors++;
        if (fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_end: got valid=%b, want 0", fetch_valid);
        end
    endtask

    task automatic test_reset_mid_ops();
        int n;
        fetch_req  = 1'b1;
        fetch_addr = 12'h014;
        tick();
        reset = 1'b1;
        #1;
        vectors++;
        if (fetch_valid !== 1'b0 || fetch_inst !== NOP || fetch_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_fetch: got v=%b inst=%h err=%b busy=%b, want 0 %h 0 1",
                     fetch_valid, fetch_inst, fetch_err, busy, NOP);
        end
        idle_inputs();
        boot_load = 1'b1;
        tick();
        reset = 1'b0;
        wait_clear(n);
        load_word(7'd0, 32'hAAAA_0001, 1'b0, 1'b0);
        load_word(7'd1, 32'hAAAA_0002, 1'b0, 1'b0);
        load_word(7'd2, 32'hAAAA_0003, 1'b0, 1'b0);
        load_valid = 1'b1;
        load_addr  = 7'd3;
        load_data  = 32'hAAAA_0004;
        #2;
        reset = 1'b1;
        #1;
        idle_inputs();
        boot_load = 1'b0;
        tick();
        reset = 1'b0;
        wait_clear(n);
        vectors++;
        if (n !== DEPTH || fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL reclear_length: got n=%0d fr=%b, want %0d 1", n, fetch_ready, DEPTH);
        end
        expect_fetch("reclear_w0", 12'h000, NOP, 1'b0);
        expect_fetch("reclear_w1", 12'h004, NOP, 1'b0);
        expect_fetch("reclear_w2", 12'h008, NOP, 1'b0);
        expect_fetch("reclear_w3", 12'h00C, NOP, 1'b0);
        expect_fetch("reclear_w5", 12'h014, NOP, 1'b0);
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        int n;
        apply_reset(1'b1);
        wait_clear(n);
        load_word(7'd2, 32'h0040_0213, 1'b0, 1'b1);
        load_word(7'd3, 32'h0050_0293, 1'b1, 1'b0);
        expect_fetch("parity_injected", 12'h008, NOP, 1'b1);
        expect_fetch("parity_clean", 12'h00C, 32'h0050_0293, 1'b0);
        expect_fetch("parity_cleared", 12'h010, NOP, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_faults();
        test_back_to_back();
        test_reset_mid_ops();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
